// File: rtl/biphase_pwm_gen.sv
// ---------------------------------------------------------------------------
// biphase_pwm_gen
//   Two-phase interleaved PWM generator with dead time for a bi-phase
//   half-bridge DC-DC stage. Bus words from the MCU register block arrive
//   asynchronously, are resynchronised with a stability filter, staged, and
//   double-buffered into shadow registers at the period wrap.
//
//   Ports
//     clk        system clock (only domain)
//     rst_n      asynchronous active-low reset
//     period_in  requested period in clk cycles (async bus word)
//     duty_in    requested high-side on-time in clk cycles (async bus word)
//     ctrl_in    [15] enable, [7:0] dead time in clk cycles (async bus word)
//     pwm_ah/al  phase A high/low-side gates
//     pwm_bh/bl  phase B high/low-side gates, 180 degrees from phase A
//     adc_trig   one-clk pulse in the clk after cnt == 0 while enabled
//     cnt_rd     registered copy of the live period counter
// ---------------------------------------------------------------------------

// Dead-time unit for one half-bridge phase. Gates follow the raw compare
// only after it has been stable for dt_i clks; any raw change drops both
// gates first, so H and L can never be high in the same cycle.
module biphase_pwm_gen_dead (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic       raw_i,
    input  logic [7:0] dt_i,
    output logic       gate_h_o,
    output logic       gate_l_o
);
    typedef enum logic [1:0] {
        OFF_BOTH = 2'd0,
        HIGH_ON  = 2'd1,
        LOW_ON   = 2'd2
    } state_e;

    state_e     state_q;
    logic [7:0] dcnt_q;
    logic       raw_last_q;
    logic       gate_h_q;
    logic       gate_l_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFF_BOTH;
            dcnt_q     <= 8'd0;
            raw_last_q <= 1'b0;
            gate_h_q   <= 1'b0;
            gate_l_q   <= 1'b0;
        end else if (!en_i) begin
            state_q    <= OFF_BOTH;
            dcnt_q     <= 8'd0;
            raw_last_q <= raw_i;
            gate_h_q   <= 1'b0;
            gate_l_q   <= 1'b0;
        end else begin
            case (state_q)
                HIGH_ON, LOW_ON: begin
                    if (raw_i != raw_last_q) begin
                        raw_last_q <= raw_i;
                        if (dt_i == 8'd0) begin
                            // Zero dead time: swap gates directly; both come
                            // from the same state so they still never overlap.
                            state_q  <= raw_i ? HIGH_ON : LOW_ON;
                            gate_h_q <= raw_i;
                            gate_l_q <= !raw_i;
                        end else begin
                            state_q  <= OFF_BOTH;
                            dcnt_q   <= 8'd1;
                            gate_h_q <= 1'b0;
                            gate_l_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    if ((raw_i != raw_last_q) && (dt_i != 8'd0)) begin
                        // Toggle while waiting: restart so short pulses are swallowed.
                        raw_last_q <= raw_i;
                        dcnt_q     <= 8'd1;
                    end else if (dcnt_q >= dt_i) begin
                        state_q    <= raw_i ? HIGH_ON : LOW_ON;
                        raw_last_q <= raw_i;
                        gate_h_q   <= raw_i;
                        gate_l_q   <= !raw_i;
                    end else begin
                        dcnt_q <= dcnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign gate_h_o = gate_h_q;
    assign gate_l_o = gate_l_q;
endmodule

module biphase_pwm_gen #(
    parameter logic [15:0] PER_RST  = 16'd10000,
    parameter logic [7:0]  DEAD_RST = 8'd8,
    parameter logic [15:0] PER_MIN  = 16'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] period_in,
    input  logic [15:0] duty_in,
    input  logic [15:0] ctrl_in,
    output logic        pwm_ah,
    output logic        pwm_al,
    output logic        pwm_bh,
    output logic        pwm_bl,
    output logic        adc_trig,
    output logic [15:0] cnt_rd
);
    // Only enable and dead-time bits of the control word are carried.
    localparam logic [8:0] CTRL_RST = {1'b0, DEAD_RST};

    logic [8:0] ctrl_w;
    logic       unused_ctrl;
    assign ctrl_w      = {ctrl_in[15], ctrl_in[7:0]};
    assign unused_ctrl = ^ctrl_in[14:8];

    // Resynchroniser: two flops, a compare flop, and a staged register that
    // only accepts a word seen identical on two consecutive clks.
    logic [15:0] per_s1_q, per_s2_q, per_s3_q, per_stg_q;
    logic [15:0] duty_s1_q, duty_s2_q, duty_s3_q, duty_stg_q;
    logic [8:0]  ctrl_s1_q, ctrl_s2_q, ctrl_s3_q, ctrl_stg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_s1_q   <= PER_RST;
            per_s2_q   <= PER_RST;
            per_s3_q   <= PER_RST;
            per_stg_q  <= PER_RST;
            duty_s1_q  <= 16'd0;
            duty_s2_q  <= 16'd0;
            duty_s3_q  <= 16'd0;
            duty_stg_q <= 16'd0;
            ctrl_s1_q  <= CTRL_RST;
            ctrl_s2_q  <= CTRL_RST;
            ctrl_s3_q  <= CTRL_RST;
            ctrl_stg_q <= CTRL_RST;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, so the s1->s2->s3 chain shifts one stage per clk.
            per_s1_q  <= period_in;
            per_s2_q  <= per_s1_q;
            per_s3_q  <= per_s2_q;
            duty_s1_q <= duty_in;
            duty_s2_q <= duty_s1_q;
            duty_s3_q <= duty_s2_q;
            ctrl_s1_q <= ctrl_w;
            ctrl_s2_q <= ctrl_s1_q;
            ctrl_s3_q <= ctrl_s2_q;
            if (per_s2_q == per_s3_q) per_stg_q <= per_s2_q;
            if (duty_s2_q == duty_s3_q) duty_stg_q <= duty_s2_q;
            if (ctrl_s2_q == ctrl_s3_q) ctrl_stg_q <= ctrl_s2_q;
        end
    end

    logic        en_q;
    logic [15:0] per_sh_q, duty_sh_q;
    logic [7:0]  dt_sh_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_rd_q;
    logic        trig_q;

    logic [15:0] p_eff, d_eff, h_eff, cnt_b;
    logic        wrap, load_sh, raw_a, raw_b;

    assign p_eff   = (per_sh_q < PER_MIN) ? PER_MIN : per_sh_q;
    assign d_eff   = (duty_sh_q > p_eff) ? p_eff : duty_sh_q;
    assign h_eff   = p_eff >> 1;
    assign wrap    = en_q && (cnt_q >= p_eff - 16'd1);
    // Shadows track staged continuously while disabled, else only at wrap.
    assign load_sh = !en_q || wrap;
    assign cnt_d   = (en_q && !wrap) ? cnt_q + 16'd1 : 16'd0;

    // Phase B sees the counter rotated by half a period.
    assign cnt_b = (cnt_q < h_eff) ? cnt_q + (p_eff - h_eff) : cnt_q - h_eff;
    assign raw_a = (cnt_q < d_eff);
    assign raw_b = (cnt_b < d_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            per_sh_q  <= PER_RST;
            duty_sh_q <= 16'd0;
            dt_sh_q   <= DEAD_RST;
            cnt_q     <= 16'd0;
            cnt_rd_q  <= 16'd0;
            trig_q    <= 1'b0;
        end else begin
            en_q <= ctrl_stg_q[8];
            if (load_sh) begin
                per_sh_q  <= per_stg_q;
                duty_sh_q <= duty_stg_q;
                dt_sh_q   <= ctrl_stg_q[7:0];
            end
            cnt_q    <= cnt_d;
            cnt_rd_q <= en_q ? cnt_q : 16'd0;
            trig_q   <= en_q && (cnt_q == 16'd0);
        end
    end

    biphase_pwm_gen_dead u_dead_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_q),
        .raw_i    (raw_a),
        .dt_i     (dt_sh_q),
        .gate_h_o (pwm_ah),
        .gate_l_o (pwm_al)
    );

    biphase_pwm_gen_dead u_dead_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_q),
        .raw_i    (raw_b),
        .dt_i     (dt_sh_q),
        .gate_h_o (pwm_bh),
        .gate_l_o (pwm_bl)
    );

    assign adc_trig = trig_q;
    assign cnt_rd   = cnt_rd_q;
endmodule
